// File: rtl/enemy_lane_if.sv
// Player/game-control side of one falling-byte lane: respawn, speed, fire and value in;
// target, row and the correct/game_over status levels out.
`timescale 1ns/1ps
interface enemy_lane_if;
    logic       respawn;
    logic [2:0] speed_level;
    logic       fire;
    logic [7:0] player_value;
    logic [7:0] target;
    logic [3:0] row;
    logic       active;
    logic       correct;
    logic       game_over;

    modport master (
        output respawn, speed_level, fire, player_value,
        input  target, row, active, correct, game_over
    );

    modport slave (
        input  respawn, speed_level, fire, player_value,
        output target, row, active, correct, game_over
    );
endinterface

// File: rtl/enemy_lane.sv
// One Flippy Bit lane: spawns an LFSR byte, drops it one row per tick, flags match or landing.
// Status levels change one cycle after the deciding input; no backpressure, respawn overrides all.
`timescale 1ns/1ps
module enemy_lane #(
    parameter int         ROWS      = 8,
    parameter int         TICK_DIV  = 50000000,
    parameter logic [7:0] LFSR_SEED = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    enemy_lane_if.slave lane
);
    typedef enum logic [2:0] {IDLE, SPAWN, FALLING, HIT, LANDED} state_t;

    localparam logic [25:0] DIV_BASE = 26'(TICK_DIV);
    localparam logic [3:0]  LAST_ROW = 4'(ROWS - 1);

    state_t      state_q, state_d;
    logic [7:0]  target_q, target_d;
    logic [3:0]  row_q, row_d;
    logic        active_q, active_d;
    logic        correct_q, correct_d;
    logic        game_over_q, game_over_d;
    logic [25:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        fire_q;

    logic [25:0] div_shift, div;
    logic        tick, fire_rise, match;

    // Galois form of x^8+x^6+x^5+x^4+1; a non-zero seed never reaches zero
    assign lfsr_d    = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
    assign div_shift = DIV_BASE >> lane.speed_level;
    assign div       = (div_shift == 26'd0) ? 26'd1 : div_shift;
    // >= so that a speed-up leaving the counter past the new limit ticks at once
    assign tick      = (cnt_q >= div - 26'd1);
    assign fire_rise = lane.fire & ~fire_q;
    assign match     = fire_rise && (lane.player_value == target_q);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            target_q    <= 8'h00;
            row_q       <= 4'd0;
            active_q    <= 1'b0;
            correct_q   <= 1'b0;
            game_over_q <= 1'b0;
            cnt_q       <= 26'd0;
            lfsr_q      <= LFSR_SEED;
            fire_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            row_q       <= row_d;
            active_q    <= active_d;
            correct_q   <= correct_d;
            game_over_q <= game_over_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            fire_q      <= lane.fire;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        row_d       = row_q;
        active_d    = active_q;
        correct_d   = correct_q;
        game_over_d = game_over_q;
        cnt_d       = cnt_q;
        case (state_q)
            SPAWN: begin
                target_d    = lfsr_q;
                row_d       = 4'd0;
                cnt_d       = 26'd0;
                correct_d   = 1'b0;
                game_over_d = 1'b0;
                active_d    = 1'b0;
                if (!lane.respawn) begin
                    state_d  = FALLING;
                    active_d = 1'b1;
                end
            end
            FALLING: begin
                if (match) begin
                    state_d   = HIT;
                    correct_d = 1'b1;
                    active_d  = 1'b0;
                end else if (tick) begin
                    cnt_d = 26'd0;
                    if (row_q == LAST_ROW) begin
                        state_d     = LANDED;
                        game_over_d = 1'b1;
                        active_d    = 1'b0;
                    end else begin
                        row_d = row_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: ;
        endcase
        // Status clears the cycle after respawn, not after the first SPAWN cycle
        if (lane.respawn) begin
            state_d     = SPAWN;
            correct_d   = 1'b0;
            game_over_d = 1'b0;
            active_d    = 1'b0;
        end
    end

    assign lane.target    = target_q;
    assign lane.row       = row_q;
    assign lane.active    = active_q;
    assign lane.correct   = correct_q;
    assign lane.game_over = game_over_q;
endmodule

// File: tb/tb_enemy_lane.sv
// Bench for enemy_lane: two lanes (fast divisor and speed-scaled divisor) against an LFSR model
// and a queue of expected spawn targets.
`timescale 1ns/1ps
module tb_enemy_lane;
    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    enemy_lane_if ia();
    enemy_lane_if ib();

    enemy_lane #(.ROWS(4), .TICK_DIV(4),  .LFSR_SEED(8'hA5)) u_a (.clock(clock), .reset(reset), .lane(ia));
    enemy_lane #(.ROWS(4), .TICK_DIV(16), .LFSR_SEED(8'h5C)) u_b (.clock(clock), .reset(reset), .lane(ib));

    always #5 clock = ~clock;

    logic [7:0] ma, mb, mb_prev;
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] n;
        n = v >> 1;
        if (v[0]) n = n ^ 8'b1011_1000;
        return n;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            ma      <= 8'hA5;
            mb      <= 8'h5C;
            mb_prev <= 8'h00;
        end else begin
            ma      <= lfsr_step(ma);
            mb      <= lfsr_step(mb);
            mb_prev <= mb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pop_a(output logic [7:0] t);
        if (qa.size() == 0) begin
            chk("sb_a_empty", 1, 0);
            t = 8'h00;
        end else begin
            t = qa.pop_front();
        end
    endtask

    task automatic spawn_a(output logic [7:0] t);
        ia.respawn = 1'b1;
        step(1);
        chk("resp_correct", ia.correct, 0);
        chk("resp_game_over", ia.game_over, 0);
        chk("resp_active", ia.active, 0);
        ia.respawn = 1'b0;
        qa.push_back(ma);
        step(1);
        pop_a(t);
        chk("spawn_active", ia.active, 1);
        chk("spawn_target", ia.target, t);
        chk("spawn_row", ia.row, 0);
        chk("spawn_nonzero", (ia.target != 8'h00), 1);
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_target"}, ia.target, 0);
        chk({tag, "_row"}, ia.row, 0);
        chk({tag, "_active"}, ia.active, 0);
        chk({tag, "_correct"}, ia.correct, 0);
        chk({tag, "_game_over"}, ia.game_over, 0);
    endtask

    initial begin
        logic [7:0] t;
        reset = 1'b1;
        ia.respawn = 1'b0; ia.speed_level = 3'd0; ia.fire = 1'b0; ia.player_value = 8'h00;
        ib.respawn = 1'b0; ib.speed_level = 3'd2; ib.fire = 1'b0; ib.player_value = 8'h00;
        step(2);
        check_idle_a("reset");
        reset = 1'b0;
        step(3);
        check_idle_a("idle");
        chk("idle_b_target", ib.target, 0);

        // Full fall to landing: row steps every 4 cycles, game_over after the 16th cycle
        spawn_a(t);
        for (int i = 1; i <= 16; i++) begin
            step(1);
            if (i < 16) begin
                chk("fall_row", ia.row, i / 4);
                chk("fall_active", ia.active, 1);
                chk("fall_game_over", ia.game_over, 0);
            end else begin
                chk("land_game_over", ia.game_over, 1);
                chk("land_active", ia.active, 0);
                chk("land_row", ia.row, 3);
            end
        end
        step(3);
        chk("land_hold", ia.game_over, 1);
        chk("land_correct", ia.correct, 0);

        // Matching fire mid-fall, then a long hold changes nothing
        spawn_a(t);
        step(5);
        ia.player_value = t;
        ia.fire = 1'b1;
        step(1);
        chk("hit_correct", ia.correct, 1);
        chk("hit_active", ia.active, 0);
        chk("hit_row", ia.row, 1);
        step(20);
        chk("hit_hold_correct", ia.correct, 1);
        chk("hit_hold_row", ia.row, 1);
        chk("hit_hold_target", ia.target, t);
        chk("hit_hold_go", ia.game_over, 0);
        ia.fire = 1'b0;

        // Mismatch ignored; a fresh rising edge with the right value hits
        spawn_a(t);
        step(2);
        ia.player_value = t ^ 8'h01;
        ia.fire = 1'b1;
        step(3);
        chk("miss_correct", ia.correct, 0);
        chk("miss_active", ia.active, 1);
        ia.fire = 1'b0;
        step(1);
        ia.player_value = t;
        ia.fire = 1'b1;
        step(1);
        chk("refire_correct", ia.correct, 1);
        ia.fire = 1'b0;

        // Value corrected while fire is held: no new edge, no hit
        spawn_a(t);
        step(1);
        ia.player_value = t ^ 8'h01;
        ia.fire = 1'b1;
        step(2);
        ia.player_value = t;
        step(3);
        chk("held_correct", ia.correct, 0);
        chk("held_active", ia.active, 1);
        ia.fire = 1'b0;
        step(1);

        // Match on the final tick cycle: hit beats landing
        spawn_a(t);
        ia.player_value = t;
        step(15);
        chk("pre_final_row", ia.row, 3);
        ia.fire = 1'b1;
        step(1);
        chk("final_correct", ia.correct, 1);
        chk("final_game_over", ia.game_over, 0);
        chk("final_row", ia.row, 3);
        ia.fire = 1'b0;
        step(2);
        chk("final_hold_go", ia.game_over, 0);

        // Lane B: respawn held 3 cycles, speed_level 2 on TICK_DIV 16
        ib.respawn = 1'b1;
        step(3);
        chk("b_hold_active", ib.active, 0);
        chk("b_hold_target", ib.target, mb_prev);
        chk("b_hold_row", ib.row, 0);
        ib.respawn = 1'b0;
        qb.push_back(mb);
        step(1);
        chk("b_spawn_active", ib.active, 1);
        if (qb.size() == 0) chk("sb_b_empty", 1, 0);
        else chk("b_spawn_target", ib.target, qb.pop_front());
        for (int i = 1; i <= 12; i++) begin
            step(1);
            chk("b_fall_row", ib.row, i / 4);
        end

        // Reset during FALLING and during HIT
        spawn_a(t);
        step(3);
        reset = 1'b1;
        step(1);
        check_idle_a("rst_fall");
        reset = 1'b0;
        step(5);
        check_idle_a("rst_fall_idle");
        spawn_a(t);
        ia.player_value = t;
        ia.fire = 1'b1;
        step(1);
        chk("pre_rst_correct", ia.correct, 1);
        reset = 1'b1;
        ia.fire = 1'b0;
        step(1);
        check_idle_a("rst_hit");
        reset = 1'b0;
        step(3);
        check_idle_a("rst_hit_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
